// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard controller FSM states and forwarding select encodings.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MC_WAIT  = 2'b01,
    MEM_WAIT = 2'b10
  } hazard_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// EX operand forwarding select for one source register; MEM result takes precedence over WB.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] rd_w,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing and operand forwarding for the five-stage pipeline.
// Define PIPE_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic              mc_start_e,
  input  logic              mc_done,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  hazard_state_t state_q, state_d;
  logic          lw;
  fwd_sel_t      fwd_a, fwd_b;

  assign lw = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    state_d = state_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req_m && !dmem_ready) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_d = MEM_WAIT;
        end else if (mc_start_e) begin
          {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
          if (!mc_done) state_d = MC_WAIT;
        end else if (pc_src_e) begin
          // A redirect squashes a concurrent load-use; the bubble is moot.
          {flush_d, flush_e} = 2'b11;
        end else if (lw) begin
          {stall_f, stall_d, flush_e} = 3'b111;
        end
      end
      MC_WAIT: begin
        // The completion cycle is still held so the result can be captured.
        {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
        if (mc_done) state_d = RUN;
      end
      MEM_WAIT: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        if (dmem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m} = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (rs1_e),
    .reg_write_m (reg_write_m),
    .rd_m        (rd_m),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .sel         (fwd_a)
  );

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (rs2_e),
    .reg_write_m (reg_write_m),
    .rd_m        (rd_m),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .sel         (fwd_b)
  );

  assign fwd_a_e = reset ? FWD_RF : fwd_a;
  assign fwd_b_e = reset ? FWD_RF : fwd_b;

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = 1;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CntOne;
      if (flush_e && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CntOne;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
